// File: rtl/pc_unit.sv
// Fetch program counter: advances by INC each unstalled cycle. Exception, branch and jump
// redirects use fixed priority, and a redirect seen during a stall is held until release.
module pc_unit #(
    parameter int unsigned     WIDTH        = 32,
    parameter int unsigned     INC          = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h0000_0080,
    parameter int unsigned     ALIGN_BITS   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             exc,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next_seq,
    output logic             redirected,
    output logic             misalign,
    output logic             pending
);

    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    logic [WIDTH-1:0] low_mask;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
    logic             pending_q, pending_d;
    logic             redirected_q, redirected_d;
    logic             misalign_q, misalign_d;

    logic [WIDTH-1:0] req_tgt;
    logic [WIDTH-1:0] tgt_aligned;
    logic             tgt_misal;
    logic             br_or_jmp;

    // Bits below ALIGN_BITS form the alignment mask; works for ALIGN_BITS == 0 as well.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
        if (gi < ALIGN_BITS) begin : g_lo
            assign low_mask[gi] = 1'b1;
        end else begin : g_hi
            assign low_mask[gi] = 1'b0;
        end
    end

    always_comb begin
        br_or_jmp   = branch_taken | jump;
        req_tgt     = branch_taken ? branch_target : jump_target;
        tgt_aligned = req_tgt & ~low_mask;
        tgt_misal   = |(req_tgt & low_mask);

        pc_d         = pc_q;
        pending_d    = pending_q;
        pend_tgt_d   = pend_tgt_q;
        redirected_d = 1'b0;
        misalign_d   = 1'b0;

        if (exc) begin
            pc_d         = EXC_VECTOR;
            pending_d    = 1'b0;
            redirected_d = 1'b1;
        end else if (stall) begin
            // Newest stalled request wins; the target is stored already aligned,
            // so the misalign pulse is raised once, here at capture.
            if (br_or_jmp) begin
                pending_d  = 1'b1;
                pend_tgt_d = tgt_aligned;
                misalign_d = tgt_misal;
            end
        end else if (br_or_jmp) begin
            pc_d         = tgt_aligned;
            pending_d    = 1'b0;
            redirected_d = 1'b1;
            misalign_d   = tgt_misal;
        end else if (pending_q) begin
            pc_d         = pend_tgt_q;
            pending_d    = 1'b0;
            redirected_d = 1'b1;
        end else begin
            pc_d = pc_q + INC_W;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_VECTOR;
            pending_q    <= 1'b0;
            pend_tgt_q   <= '0;
            redirected_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            pending_q    <= pending_d;
            pend_tgt_q   <= pend_tgt_d;
            redirected_q <= redirected_d;
            misalign_q   <= misalign_d;
        end
    end

    assign pc          = pc_q;
    assign pc_next_seq = pc_q + INC_W;
    assign redirected  = redirected_q;
    assign misalign    = misalign_q;
    assign pending     = pending_q;

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the pipelined MIPS core, sitting at the front of the IF stage. It holds the fetch PC, advances it by a fixed increment, and applies exception, branch and jump redirects with fixed priority. A redirect that arrives while the pipeline is stalled is captured in a one-entry pending register and applied when the stall releases. It reports a one-cycle flush pulse and a misalignment flag on each redirect.

## Interface
- WIDTH, 32, PC width in bits.
- INC, 4, increment added per unstalled cycle.
- RESET_VECTOR, 32'h0000_0000, PC value loaded by reset.
- EXC_VECTOR, 32'h0000_0080, PC value loaded on exception.
- ALIGN_BITS, 2, number of low target bits that must be zero.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC (hazard unit).
- exc  in  1  exception request.
- branch_taken  in  1  branch redirect request.
- branch_target  in  WIDTH  branch destination.
- jump  in  1  jump redirect request.
- jump_target  in  WIDTH  jump destination.
- pc  out  WIDTH  current fetch PC (registered).
- pc_next_seq  out  WIDTH  combinational pc + INC, for link/branch base.
- redirected  out  1  registered pulse: pc was loaded from a redirect or pending target on the previous edge.
- misalign  out  1  registered pulse: last loaded target had nonzero low ALIGN_BITS bits.
- pending  out  1  a stalled redirect is held.

## Operation
- Request select, per cycle: exc > branch_taken > jump. req = exc | branch_taken | jump; tgt = EXC_VECTOR, branch_target or jump_target, respectively.
- Loaded targets have their low ALIGN_BITS bits forced to zero. misalign is set when the raw tgt had any of those bits set. EXC_VECTOR is never flagged.
- Edge behaviour, evaluated in order:
  - rst: pc=RESET_VECTOR, pending=0, pending target=0, redirected=0, misalign=0.
  - exc (ignores stall): pc=EXC_VECTOR, pending cleared, redirected=1.
  - stall and req (branch/jump): pc holds; pending=1; pending target=tgt. A newer request overwrites an older pending one. misalign is evaluated at capture.
  - stall, no req: pc and pending hold; redirected=0.
  - no stall, req: pc=tgt, pending cleared, redirected=1. The current request beats the pending one.
  - no stall, no req, pending: pc=pending target, pending cleared, redirected=1.
  - otherwise: pc=pc+INC, modulo 2^WIDTH; redirected=0.
- misalign pulses for exactly one cycle per offending capture or load. It is 0 otherwise.

## Timing
- Latency: a redirect presented in cycle N appears on pc after edge N+1. redirected is high during cycle N+1 only.
- A stalled redirect applies on the first edge where stall=0. redirected is high for the following cycle.
- pc_next_seq is purely combinational from pc, with zero latency.
- Wrap: pc=2^WIDTH−INC advances to 0 with no flag.
- rst asserted mid-stall or with a pending redirect discards the pending redirect. pc=RESET_VECTOR the cycle after.
- Simultaneous exc and stall: exception wins; pending cleared.
- Simultaneous branch_taken and jump: branch wins; jump dropped.
- After reset all outputs are stable with pending=0.

## Test plan
- Reset then 4 free-run cycles -> pc 0x0, 0x4, 0x8, 0xC; pc_next_seq=pc+4; redirected=0.
- branch_taken=1, branch_target=0x100 at pc=0x8 -> next pc=0x100, redirected=1 for one cycle, then 0x104.
- stall=1 for 3 cycles; jump_target=0x40 in stall cycle 1, then branch_target=0x200 in cycle 2 -> pc holds, pending=1. After stall drops, pc=0x200 and 0x40 is discarded.
- stall=1 with a pending redirect to 0x300, exc=1 -> pc=0x80, pending=0, redirected=1.
- branch_target=0x103 -> pc=0x100, misalign=1 for one cycle.
- pc=0xFFFF_FFFC free-run -> pc=0x0. rst asserted with pending=1 -> pc=0x0, pending=0 on the next cycle.
